// File: rtl/lsu_port_pkg.sv
// rtl/lsu_port_pkg.sv - shared encodings and state type for the load/store port
package lsu_port_pkg;

  localparam logic [31:0] LSU_MEM_BASE = 32'h0100_0000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Stores only exist as B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of raw load data by funct3
module load_extend
  import lsu_port_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// rtl/lsu_port.sv - RISC-V load/store unit port onto a combinational byte-addressed memory
module lsu_port
  import lsu_port_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = LSU_MEM_BASE,
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  localparam logic [32:0] MEM_LIMIT = {1'b0, MEM_BASE} + 33'(MEM_BYTES);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic [32:0] req_end;
  logic        req_bad;
  logic        req_split;
  logic [31:0] raw_beat;
  logic [31:0] ext_raw;
  logic [31:0] ext_data;
  logic [1:0]  last_beat;

  // Last byte computed with a carry bit so a wrap past 2^32 lands above MEM_LIMIT.
  always_comb begin
    case (req_funct3[1:0])
      SZ_BYTE: req_end = {1'b0, req_addr};
      SZ_HALF: req_end = {1'b0, req_addr} + 33'd1;
      default: req_end = {1'b0, req_addr} + 33'd3;
    endcase
    req_bad   = f3_illegal(req_funct3, req_store) || (req_addr < MEM_BASE) ||
                req_end[32] || (req_end >= MEM_LIMIT);
    req_split = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    raw_beat = data_q;
    raw_beat[{beat_q, 3'b000} +: 8] = mem_data_out[7:0];
  end

  assign ext_raw   = (state_q == ST_SPLIT) ? raw_beat : mem_data_out;
  assign last_beat = (funct3_q[1:0] == SZ_WORD) ? 2'd3 : 2'd1;

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (ext_raw),
    .result (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    beat_d   = beat_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          data_d   = 32'd0;
          rdata_d  = 32'd0;
          beat_d   = 2'd0;
          err_d    = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_split) begin
            state_d = ST_SPLIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        rdata_d = store_q ? 32'd0 : ext_data;
        state_d = ST_RESP;
      end
      ST_SPLIT: begin
        data_d = raw_beat;
        beat_d = beat_q + 2'd1;
        if (beat_q == last_beat) begin
          rdata_d = store_q ? 32'd0 : ext_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_address     = MEM_BASE;
    mem_access_size = SZ_BYTE;
    mem_data_in     = 32'd0;
    mem_read_write  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        mem_address     = addr_q;
        mem_access_size = funct3_q[1:0];
        mem_data_in     = wdata_q;
        mem_read_write  = store_q;
      end
      ST_SPLIT: begin
        mem_address     = addr_q + {30'd0, beat_q};
        mem_access_size = SZ_BYTE;
        mem_data_in     = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
        mem_read_write  = store_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      beat_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_lsu_port.sv
// tb/tb_lsu_port.sv - directed vector bench for lsu_port against a byte-array memory model
module tb_lsu_port;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock, reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;

  lsu_port #(.MEM_BASE(BASE), .MEM_BYTES(1048576)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_data_out(mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model memory aliases on the low address byte; tests stay within that window per region.
  logic [7:0]  mem [256];
  logic [7:0]  ma;
  int          wr_cnt;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [1:0]  wlog_size[$];

  assign ma = mem_address[7:0];

  always_comb begin
    case (mem_access_size)
      2'd0:    mem_data_out = {24'd0, mem[ma]};
      2'd1:    mem_data_out = {16'd0, mem[ma + 8'd1], mem[ma]};
      default: mem_data_out = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    endcase
  end

  always @(posedge clock) begin
    if (mem_read_write) begin
      wr_cnt++;
      wlog_addr.push_back(mem_address);
      wlog_data.push_back(mem_data_in);
      wlog_size.push_back(mem_access_size);
      mem[ma] <= mem_data_in[7:0];
      if (mem_access_size != 2'd0) mem[ma + 8'd1] <= mem_data_in[15:8];
      if (mem_access_size == 2'd2) begin
        mem[ma + 8'd2] <= mem_data_in[23:16];
        mem[ma + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vecs[24];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, w0;
    logic        seen;

    vecs[0]  = '{1'b1, 3'b010, 32'h0100_0000, 32'hDEAD_BEEF, 32'h0,          1'b0, 2, 1};
    vecs[1]  = '{1'b0, 3'b010, 32'h0100_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0100_0003, 32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, 3'b100, 32'h0100_0003, 32'h0,         32'h0000_00DE, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0100_0002, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 3'b101, 32'h0100_0002, 32'h0,         32'h0000_DEAD, 1'b0, 2, 0};
    vecs[6]  = '{1'b1, 3'b010, 32'h0100_0001, 32'h1122_3344, 32'h0,          1'b0, 5, 4};
    vecs[7]  = '{1'b0, 3'b010, 32'h0100_0001, 32'h0,         32'h1122_3344, 1'b0, 5, 0};
    vecs[8]  = '{1'b0, 3'b001, 32'h0100_0003, 32'h0,         32'h0000_1122, 1'b0, 3, 0};
    vecs[9]  = '{1'b0, 3'b000, 32'h0100_0001, 32'h0,         32'h0000_0044, 1'b0, 2, 0};
    vecs[10] = '{1'b0, 3'b010, 32'h00FF_FFFC, 32'h0,         32'h0,          1'b1, 1, 0};
    vecs[11] = '{1'b0, 3'b011, 32'h0100_0000, 32'h0,         32'h0,          1'b1, 1, 0};
    vecs[12] = '{1'b1, 3'b100, 32'h0100_0000, 32'h55,        32'h0,          1'b1, 1, 0};
    vecs[13] = '{1'b1, 3'b010, 32'h010F_FFFC, 32'hCAFE_F00D, 32'h0,          1'b0, 2, 1};
    vecs[14] = '{1'b0, 3'b010, 32'h010F_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 0};
    vecs[15] = '{1'b0, 3'b010, 32'h010F_FFFE, 32'h0,         32'h0,          1'b1, 1, 0};
    vecs[16] = '{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0,         32'h0,          1'b1, 1, 0};
    vecs[17] = '{1'b1, 3'b001, 32'h0100_0010, 32'h1234_8001, 32'h0,          1'b0, 2, 1};
    vecs[18] = '{1'b0, 3'b001, 32'h0100_0010, 32'h0,         32'hFFFF_8001, 1'b0, 2, 0};
    vecs[19] = '{1'b0, 3'b101, 32'h0100_0010, 32'h0,         32'h0000_8001, 1'b0, 2, 0};
    vecs[20] = '{1'b1, 3'b001, 32'h0100_0013, 32'h0000_ABCD, 32'h0,          1'b0, 3, 2};
    vecs[21] = '{1'b0, 3'b101, 32'h0100_0013, 32'h0,         32'h0000_ABCD, 1'b0, 3, 0};
    vecs[22] = '{1'b1, 3'b000, 32'h0100_0020, 32'h1234_56F0, 32'h0,          1'b0, 2, 1};
    vecs[23] = '{1'b0, 3'b000, 32'h0100_0020, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 0};

    checks = 0; errors = 0; wr_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    #2;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset mem_address", mem_address, BASE);
    chk("reset mem_rw", {31'd0, mem_read_write}, 32'd0);
    chk("reset mem_size", {30'd0, mem_access_size}, 32'd0);
    chk("reset mem_data_in", mem_data_in, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      w0 = wr_cnt;
      run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d error", i), {31'd0, er}, {31'd0, vecs[i].er});
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d writes", i), wr_cnt - w0, vecs[i].nwr);
    end

    // Beat-level write log for a split word store, then an aligned one.
    wlog_addr.delete(); wlog_data.delete(); wlog_size.delete();
    run_req(1'b1, 3'b010, 32'h0100_0021, 32'hA1B2_C3D4, rd, er, lat);
    chk("split log count", wlog_addr.size(), 4);
    if (wlog_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("split beat%0d addr", i), wlog_addr[i], 32'h0100_0021 + i);
        chk($sformatf("split beat%0d size", i), {30'd0, wlog_size[i]}, 32'd0);
      end
      chk("split beat0 data", wlog_data[0], 32'h0000_00D4);
      chk("split beat1 data", wlog_data[1], 32'h0000_00C3);
      chk("split beat2 data", wlog_data[2], 32'h0000_00B2);
      chk("split beat3 data", wlog_data[3], 32'h0000_00A1);
    end
    wlog_addr.delete(); wlog_data.delete(); wlog_size.delete();
    run_req(1'b1, 3'b010, 32'h0100_0040, 32'h0102_0304, rd, er, lat);
    chk("aligned log count", wlog_addr.size(), 1);
    if (wlog_addr.size() == 1) begin
      chk("aligned log addr", wlog_addr[0], 32'h0100_0040);
      chk("aligned log size", {30'd0, wlog_size[0]}, 32'd2);
      chk("aligned log data", wlog_data[0], 32'h0102_0304);
    end

    // Response back-pressure.
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0100_0040;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'h0102_0304);
      chk($sformatf("stall%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d mem_address", c), mem_address, BASE);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall release req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("after release req_ready", {31'd0, req_ready}, 32'd1);
    chk("after release rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset during the second beat of a split store.
    w0 = wr_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0100_0031; req_wdata = 32'h5566_7788;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    chk("beat1 mem_address", mem_address, 32'h0100_0032);
    chk("beat1 mem_rw", {31'd0, mem_read_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset req_ready", {31'd0, req_ready}, 32'd1);
    chk("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset rsp_rdata", rsp_rdata, 32'd0);
    chk("midreset rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("midreset mem_address", mem_address, BASE);
    chk("midreset mem_rw", {31'd0, mem_read_write}, 32'd0);
    chk("midreset mem_size", {30'd0, mem_access_size}, 32'd0);
    chk("midreset mem_data_in", mem_data_in, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("midreset no response", {31'd0, seen}, 32'd0);
    chk("midreset writes", wr_cnt - w0, 1);
    chk("midreset byte0", {24'd0, mem[8'h31]}, 32'h88);
    chk("midreset byte1", {24'd0, mem[8'h32]}, 32'h00);
    chk("midreset byte2", {24'd0, mem[8'h33]}, 32'h00);
    chk("midreset byte3", {24'd0, mem[8'h34]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h01000000, meaning the byte address of data-memory location 0.
REQ-002 SHALL have parameter MEM_BYTES, default 1048576, meaning the data-memory size in bytes.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  pipeline presents a load/store.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_store  input  1  1=store, 0=load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  pipeline consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data (0 for stores).
REQ-014 SHALL have port rsp_error  output  1  illegal funct3 or out-of-range address.
REQ-015 SHALL have ports mem_address (output, 32), mem_read_write (output, 1, 1=write), mem_data_in (output, 32), mem_access_size (output, 2; 0=byte, 1=half, 2=word) and mem_data_out (input, 32), driving the combinational-read byte-addressed data memory.

Function
REQ-016 SHALL use states IDLE, ACCESS, SPLIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL register req_* and leave IDLE on req_valid&&req_ready.
REQ-018 SHALL go to RESP with rsp_error=1 and no memory access when funct3 is illegal (011, 110, 111; store with bit2=1) or when any byte of the access lies outside [MEM_BASE, MEM_BASE+MEM_BYTES).
REQ-019 For an aligned access (H: addr[0]=0; W: addr[1:0]=0; B: always), ACCESS SHALL last exactly one cycle, driving size 0/1/2, mem_read_write=req_store, and capturing mem_data_out; the next state SHALL be RESP.
REQ-020 For a misaligned access, SPLIT SHALL issue N byte accesses (N=2 for H, N=4 for W), one per cycle, at addr+i for i=0..N-1 in increasing order; store beats SHALL drive wdata byte i; load beats SHALL capture mem_data_out[7:0] into result byte i.
REQ-021 SHALL sign-extend loads for funct3 000/001 and zero-extend them for 100/101; W SHALL pass through unchanged.
REQ-022 Latency from accept to rsp_valid SHALL be 2 cycles for aligned accesses, 1+N for split accesses and 1 for errors.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_error SHALL be held stable until rsp_ready=1, after which the state SHALL be IDLE on the next cycle (no same-cycle re-accept).
REQ-024 SHALL hold mem_read_write=1 for exactly one cycle per store beat and 0 in every other cycle.
REQ-025 Outside ACCESS/SPLIT, the memory port SHALL drive mem_address=MEM_BASE, mem_access_size=0, mem_data_in=0 and mem_read_write=0.
REQ-026 Address arithmetic SHALL be 32-bit modulo; an access wrapping past 32'hFFFFFFFF SHALL be an out-of-range error.

Reset
REQ-027 Reset SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0 and the memory port to its REQ-025 idle values.
REQ-028 Reset mid-split SHALL abandon the remaining beats; bytes already written SHALL remain written, and no response SHALL be produced.

Structure
REQ-029 A shared package SHALL hold the funct3 encodings, the access-size encodings, the state enum and the MEM_BASE default.
REQ-030 Sign/zero extension SHALL live in one combinational sub-module, load_extend (inputs funct3 and raw 32-bit data; output 32-bit result).

Verification
REQ-031 SW 0xDEADBEEF to 0x01000000, then LW from 0x01000000 -> rdata=0xDEADBEEF, each response 2 cycles after accept, a single write cycle with size 2.
REQ-032 LB from 0x01000003 (byte 0xDE) -> rdata=0xFFFFFFDE; LBU from the same address -> 0x000000DE.
REQ-033 SW 0x11223344 to 0x01000001 -> four consecutive byte writes at 0x01000001..0x01000004 with data 44,33,22,11; LW from the same address -> 0x11223344, latency 5.
REQ-034 LW from 0x00FFFFFC, and funct3=011 -> rsp_error=1 one cycle after accept, mem_read_write never asserted.
REQ-035 rsp_ready held low for 3 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready=0 until 1 cycle after rsp_ready rises.
REQ-036 Reset asserted during the 2nd beat of a split SW -> outputs at reset values immediately; only byte 0 is modified; no rsp_valid.
